instr_mem_loadable: RTL and testbench

//  Parametrised word-organised instruction memory with a registered fetch port and a byte-serial program-load port.
//  An optional post-reset clear sweep fills every word with NOP_WORD.

---
 rtl/instr_mem_loadable.sv | 225 ++++++++++++++++++++++
 tb/tb_instr_mem_loadable.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Word-organised instruction memory with a registered fetch port, a byte-serial
// program-load port and an optional post-reset NOP clear sweep.
module instr_mem_loadable #(
    parameter int          PC_SIZE        = 32,
    parameter int          MEM_SIZE       = 1024,
    parameter logic [31:0] NOP_WORD       = 32'h00000013,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic [PC_SIZE-1:0] fetch_addr,
    output logic               fetch_ready,
    output logic               instr_valid,
    output logic [31:0]        instruction,
    output logic [1:0]         instr_fault,
    input  logic               load_start,
    input  logic [PC_SIZE-1:0] load_addr,
    input  logic               load_valid,
    input  logic [7:0]         load_byte,
    input  logic               load_end,
    output logic               load_ready,
    output logic               busy
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(MEM_SIZE - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    // Misalignment outranks out-of-range; anything past the last word is out of range.
    function automatic logic [1:0] fetch_fault(input logic [PC_SIZE-1:0] addr);
        logic [1:0] res;
        if (addr[1:0] != 2'b00) begin
            res = 2'b01;
        end else if (addr[PC_SIZE-1:AW+2] != {(PC_SIZE-AW-2){1'b0}}) begin
            res = 2'b10;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

    logic [31:0]   mem_r [MEM_SIZE];

    state_t        state_r, state_nx;
    logic [AW-1:0] ptr_r, ptr_nx;
    logic [1:0]    lane_r, lane_nx;
    logic [31:0]   buf_r, buf_nx;

    logic          fetch_ready_r;
    logic          load_ready_r;
    logic          busy_r;
    logic          instr_valid_r;
    logic [31:0]   instruction_r;
    logic [1:0]    instr_fault_r;

    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [31:0]   mem_wdata_s;
    logic [31:0]   asm_s;
    logic [31:0]   asm_after_s;
    logic [1:0]    lane_eff_s;
    logic [AW-1:0] ptr_eff_s;

    logic          fetch_accept_s;
    logic          load_accept_s;
    logic [1:0]    fault_s;
    logic [31:0]   mem_rdata_s;
    logic          load_addr_unused_s;

    assign fetch_accept_s     = fetch_req & fetch_ready_r;
    assign load_accept_s      = load_valid & load_ready_r;
    assign fault_s            = fetch_fault(fetch_addr);
    assign mem_rdata_s        = mem_r[fetch_addr[AW+1:2]];
    assign load_addr_unused_s = ^{load_addr[PC_SIZE-1:AW+2], load_addr[1:0]};

    // Next-state, pointer/lane bookkeeping and the single memory write port.
    always_comb begin
        state_nx    = state_r;
        ptr_nx      = ptr_r;
        lane_nx     = lane_r;
        buf_nx      = buf_r;
        mem_we_s    = 1'b0;
        mem_waddr_s = ptr_r;
        mem_wdata_s = NOP_WORD;
        asm_s       = buf_r;
        asm_after_s = buf_r;
        lane_eff_s  = lane_r;
        ptr_eff_s   = ptr_r;

        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = ptr_r;
                mem_wdata_s = NOP_WORD;
                ptr_nx      = ptr_r + PTR_ONE;
                if (ptr_r == PTR_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_CLEAR;
                end
            end

            ST_IDLE: begin
                if (load_start) begin
                    state_nx = ST_LOAD;
                    ptr_nx   = load_addr[AW+1:2];
                    lane_nx  = 2'd0;
                    buf_nx   = 32'h0000_0000;
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            ST_LOAD: begin
                // A byte arriving with load_end lands first, then the flush sees the updated lane.
                if (load_accept_s) begin
                    asm_s[{lane_r, 3'b000} +: 8] = load_byte;
                    if (lane_r == 2'd3) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = ptr_r;
                        mem_wdata_s = asm_s;
                        ptr_eff_s   = ptr_r + PTR_ONE;
                        lane_eff_s  = 2'd0;
                        asm_after_s = 32'h0000_0000;
                    end else begin
                        lane_eff_s  = lane_r + 2'd1;
                        asm_after_s = asm_s;
                    end
                end else begin
                    lane_eff_s  = lane_r;
                    asm_after_s = buf_r;
                end

                if (load_end) begin
                    if (lane_eff_s != 2'd0) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = ptr_eff_s;
                        mem_wdata_s = asm_after_s;
                    end else begin
                        mem_we_s    = mem_we_s;
                    end
                    state_nx = ST_IDLE;
                    lane_nx  = 2'd0;
                    buf_nx   = 32'h0000_0000;
                    ptr_nx   = ptr_eff_s;
                end else begin
                    state_nx = ST_LOAD;
                    lane_nx  = lane_eff_s;
                    buf_nx   = asm_after_s;
                    ptr_nx   = ptr_eff_s;
                end
            end

            default: begin
                state_nx = ST_RESET;
                ptr_nx   = {AW{1'b0}};
                lane_nx  = 2'd0;
                buf_nx   = 32'h0000_0000;
            end
        endcase
    end

    // FSM state, load assembly registers and registered handshake/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_RESET;
            ptr_r         <= {AW{1'b0}};
            lane_r        <= 2'd0;
            buf_r         <= 32'h0000_0000;
            fetch_ready_r <= 1'b0;
            load_ready_r  <= 1'b0;
            busy_r        <= (ST_RESET != ST_IDLE);
        end else begin
            state_r       <= state_nx;
            ptr_r         <= ptr_nx;
            lane_r        <= lane_nx;
            buf_r         <= buf_nx;
            fetch_ready_r <= (state_nx == ST_IDLE);
            load_ready_r  <= (state_nx == ST_LOAD);
            busy_r        <= (state_nx != ST_IDLE);
        end
    end

    // Fetch result register; instruction and fault hold between accepted fetches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_valid_r <= 1'b0;
            instruction_r <= 32'h0000_0000;
            instr_fault_r <= 2'b00;
        end else begin
            instr_valid_r <= fetch_accept_s;
            if (fetch_accept_s) begin
                instruction_r <= (fault_s == 2'b00) ? mem_rdata_s : NOP_WORD;
                instr_fault_r <= fault_s;
            end else begin
                instruction_r <= instruction_r;
                instr_fault_r <= instr_fault_r;
            end
        end
    end

    // Storage array; writes are suppressed while reset is held so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s && reset) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign fetch_ready = fetch_ready_r;
    assign load_ready  = load_ready_r;
    assign busy        = busy_r;
    assign instr_valid = instr_valid_r;
    assign instruction = instruction_r;
    assign instr_fault = instr_fault_r;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed, table-driven bench for instr_mem_loadable (MEM_SIZE=16, clear sweep on).
module tb_instr_mem_loadable;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [1:0]  instr_fault;
    logic        load_start;
    logic [31:0] load_addr;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_end;
    logic        load_ready;
    logic        busy;

    int n_checks;
    int n_fail;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
    } fvec_t;

    fvec_t vecs[11];

    instr_mem_loadable #(
        .PC_SIZE(32),
        .MEM_SIZE(16),
        .NOP_WORD(32'h00000013),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .instr_fault(instr_fault),
        .load_start(load_start),
        .load_addr(load_addr),
        .load_valid(load_valid),
        .load_byte(load_byte),
        .load_end(load_end),
        .load_ready(load_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input string name, input logic [31:0] addr,
                            input logic [31:0] exp_instr, input logic [1:0] exp_fault);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        check({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({name, "_instr"}, instruction, exp_instr);
        check({name, "_fault"}, {30'd0, instr_fault}, {30'd0, exp_fault});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_end   = last;
        tick();
        load_valid = 1'b0;
        load_end   = 1'b0;
    endtask

    task automatic load_begin(input logic [31:0] addr);
        load_start = 1'b1;
        load_addr  = addr;
        tick();
        load_start = 1'b0;
    endtask

    task automatic sweep(input string name);
        int cnt;
        cnt = 0;
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
        check({name, "_busy_cycles"}, cnt, 32'd16);
        check({name, "_fetch_ready"}, {31'd0, fetch_ready}, 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 32'd0;
        load_start = 1'b0;
        load_addr  = 32'd0;
        load_valid = 1'b0;
        load_byte  = 8'd0;
        load_end   = 1'b0;

        vecs[0]  = '{32'h0000_0000, 32'h18171615, 2'b00};
        vecs[1]  = '{32'h0000_0010, 32'h00500093, 2'b00};
        vecs[2]  = '{32'h0000_0014, 32'h00A00113, 2'b00};
        vecs[3]  = '{32'h0000_003C, 32'h14131211, 2'b00};
        vecs[4]  = '{32'h0000_0020, 32'h0000BBAA, 2'b00};
        vecs[5]  = '{32'h0000_0024, NOP,          2'b00};
        vecs[6]  = '{32'h0000_0006, NOP,          2'b01};
        vecs[7]  = '{32'h0000_0040, NOP,          2'b10};
        vecs[8]  = '{32'h0000_0041, NOP,          2'b01};
        vecs[9]  = '{32'h0000_0004, NOP,          2'b00};
        vecs[10] = '{32'hFFFF_FFFC, NOP,          2'b10};

        // Reset state
        tick();
        tick();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_fault", {30'd0, instr_fault}, 32'd0);
        check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);

        // Clear sweep then first fetch
        reset = 1'b1;
        sweep("sweep1");
        do_fetch("fetch0", 32'h0, NOP, 2'b00);
        tick();
        check("pulse_drop", {31'd0, instr_valid}, 32'd0);
        check("instr_hold", instruction, NOP);

        // Load with a simultaneous fetch
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        load_begin(32'h10);
        fetch_req  = 1'b0;
        check("both_fetch_valid", {31'd0, instr_valid}, 32'd1);
        check("both_load_ready", {31'd0, load_ready}, 32'd1);
        check("load_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        check("load_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hA0, 1'b0); send_byte(8'h00, 1'b0);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        check("end_busy", {31'd0, busy}, 32'd0);

        // Wrapping load
        load_begin(32'h3C);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h11 + 8'(i), 1'b0);
        end
        load_end = 1'b1;
        tick();
        load_end = 1'b0;

        // Partial word flushed on the same edge as the last byte
        load_begin(32'h20);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        check("flush_idle_busy", {31'd0, busy}, 32'd0);
        check("flush_idle_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        check("flush_idle_load_ready", {31'd0, load_ready}, 32'd0);

        // Back-to-back fetch table
        for (int i = 0; i < 11; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = vecs[i].addr;
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            check($sformatf("vec%0d_instr", i), instruction, vecs[i].instr);
            check($sformatf("vec%0d_fault", i), {30'd0, instr_fault}, {30'd0, vecs[i].fault});
        end
        fetch_req = 1'b0;
        tick();
        check("table_pulse_drop", {31'd0, instr_valid}, 32'd0);
        check("table_hold", instruction, NOP);

        // Reset in the middle of a load
        load_begin(32'h30);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_instr", instruction, 32'd0);
        check("mid_rst_fault", {30'd0, instr_fault}, 32'd0);
        check("mid_rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("mid_rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        sweep("sweep2");
        do_fetch("post_partial", 32'h30, NOP, 2'b00);
        do_fetch("post_w0", 32'h00, NOP, 2'b00);
        do_fetch("post_w4", 32'h10, NOP, 2'b00);
        do_fetch("post_w8", 32'h20, NOP, 2'b00);
        do_fetch("post_w15", 32'h3C, NOP, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
